register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Architectural state block of the single-cycle RV32 core.
//   - 32x32-bit general-purpose register file (GPR): two combinational read ports, one write port.
//   - Machine-mode CSR bank: mstatus, mtvec, mepc, mcause.
//   - Feeds operands to the execute unit, takes write-back data from the PC/write-back stage.
//   - Exports a0_zero, which the top-level ebreak trap check uses to report good/bad trap.
// PARAMETERS
//   DATA_WIDTH      32   width of every GPR and CSR
//   ADDR_WIDTH      5    GPR index width; number of GPRs = 2**ADDR_WIDTH
//   CSR_ADDR_WIDTH  12   CSR address width (RISC-V csr field)
// PORTS
//   clk        in   1               single clock; all state updates on rising edge
//   rst        in   1               asynchronous reset, active-high
//   wen        in   1               GPR write enable
//   waddr      in   ADDR_WIDTH      GPR write index
//   wdata      in   DATA_WIDTH      GPR write data
//   raddr1     in   ADDR_WIDTH      GPR read index, port 1 (rs1)
//   raddr2     in   ADDR_WIDTH      GPR read index, port 2 (rs2)
//   rdata1     out  DATA_WIDTH      GPR read data, port 1
//   rdata2     out  DATA_WIDTH      GPR read data, port 2
//   a0_zero    out  1               1 when x10 (a0) == 0
//   csr_wen    in   1               CSR write enable
//   csr_addr   in   CSR_ADDR_WIDTH  CSR address, shared by read and write
//   csr_wdata  in   DATA_WIDTH      CSR write data
//   csr_rdata  out  DATA_WIDTH      CSR read data
// BEHAVIOUR
//   Reset (rst=1, asynchronous, takes effect immediately regardless of clk)
//   - All GPRs clear to 0.
//   - CSR reset values: mstatus=0x0000_1800, mtvec=0, mepc=0, mcause=0.
//   - While rst is high:
//     - rdata1/rdata2 read 0.
//     - a0_zero=1.
//     - csr_rdata reads the reset values.
//     - All writes are ignored.
//   GPR write
//   - On posedge clk, when wen=1 and waddr!=0: reg[waddr] <= wdata.
//   - Write to x0 is dropped; x0 always reads 0.
//   GPR read
//   - Purely combinational: rdataN = (raddrN==0) ? 0 : reg[raddrN]. Zero-cycle latency.
//   - Both ports may address the same register, and both return the same value.
//   Read-during-write (same index, same cycle)
//   - Without bypass: the read returns the OLD value; the new value is visible after the edge.
//   a0_zero
//   - Combinational, equals (reg[10] == 0).
//   - Updates in the cycle after a write to x10.
//   CSR addresses
//   - mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
//   CSR read
//   - Combinational: csr_rdata = selected CSR.
//   - Unmapped address reads 0.
//   CSR write
//   - On posedge clk, when csr_wen=1 and csr_addr is mapped: CSR <= csr_wdata (full 32 bits, no WARL masking).
//   - Write to an unmapped address is ignored; no exception is raised.
//   - csr_rdata during a CSR write cycle returns the OLD value, so csrrw/csrrs read-modify-write works in one cycle.
//   Simultaneous events
//   - A GPR write and a CSR write in the same cycle are independent; both commit.
//   - rst asserted mid-cycle overrides any pending write.
//   Unknowns
//   - No X propagation from state: every register has a defined reset value.
// CONFIGURATION
//   RF_BYPASS_EN
//   - Defined: write-to-read forwarding.
//     - If wen=1, waddr!=0 and raddrN==waddr, rdataN = wdata in the same cycle.
//     - a0_zero uses (wdata==0) when x10 is being written.
//     - CSR path is likewise forwarded: csr_rdata = csr_wdata when csr_wen=1 on a mapped address.
//   - Undefined: no forwarding; reads return stored state only, as above.
// TESTING
//   1. Reset: assert rst between clock edges -> all rdata=0, a0_zero=1, csr_rdata@0x300=0x1800, with no clock edge needed.
//   2. Write x5=0xDEADBEEF, then raddr1=5, raddr2=5 -> both ports read 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
//   3. Write x10=7 -> a0_zero drops to 0 after the edge; write x10=0 -> a0_zero returns to 1.
//   4. Same cycle wen=1, waddr=3, wdata=0x55, raddr1=3 -> rdata1=old value (0) without RF_BYPASS_EN; 0x55 with it.
//   5. csr_wen=1, csr_addr=0x341, csr_wdata=0x8000_0010 -> mepc reads 0x8000_0010 next cycle; write to 0x7C0 -> reads 0, other CSRs unchanged.
//   6. Write x1 and mtvec in one cycle, then assert rst mid-cycle -> both return to reset values and the pending writes are lost.

Source files
------------

// File: rtl/register_file.sv
// Architectural state of the single-cycle RV32 core: 32xGPR file plus the machine-mode CSR bank.
// Optional macro RF_BYPASS_EN adds same-cycle write-to-read forwarding on GPR, a0 and CSR paths.
module register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wen,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [ADDR_WIDTH-1:0]     raddr1,
    input  logic [ADDR_WIDTH-1:0]     raddr2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2,
    output logic                      a0_zero,
    input  logic                      csr_wen,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    input  logic [DATA_WIDTH-1:0]     csr_wdata,
    output logic [DATA_WIDTH-1:0]     csr_rdata
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = CSR_ADDR_WIDTH'('h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC   = CSR_ADDR_WIDTH'('h305);
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = CSR_ADDR_WIDTH'('h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = CSR_ADDR_WIDTH'('h342);
    localparam logic [DATA_WIDTH-1:0]     MSTATUS_RST = DATA_WIDTH'('h1800);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] gpr;
    logic [DATA_WIDTH-1:0] mstatus, mtvec, mepc, mcause;
    logic [DATA_WIDTH-1:0] a0_val;
    logic                  csr_mapped;
    logic                  gpr_wr;

    // x0 is never written, so its slot stays at the reset value of zero
    assign gpr_wr = wen && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gpr <= '0;
        else if (gpr_wr)
            gpr[waddr] <= wdata;
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : gpr[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : gpr[raddr2];
        a0_val = gpr[A0_IDX];
`ifdef RF_BYPASS_EN
        // Forwarding is suppressed under reset so reads stay at the cleared state
        if (!rst && gpr_wr && (raddr1 == waddr)) rdata1 = wdata;
        if (!rst && gpr_wr && (raddr2 == waddr)) rdata2 = wdata;
        if (!rst && gpr_wr && (waddr == A0_IDX)) a0_val = wdata;
`endif
        a0_zero = (a0_val == '0);
    end

    always_comb begin
        csr_mapped = 1'b1;
        csr_rdata  = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus;
            CSR_MTVEC:   csr_rdata = mtvec;
            CSR_MEPC:    csr_rdata = mepc;
            CSR_MCAUSE:  csr_rdata = mcause;
            default:     csr_mapped = 1'b0;
        endcase
`ifdef RF_BYPASS_EN
        if (!rst && csr_wen && csr_mapped) csr_rdata = csr_wdata;
`endif
    end

    // Full-width writes, no WARL masking; unmapped addresses fall through silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus <= MSTATUS_RST;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (csr_wen) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus <= csr_wdata;
                CSR_MTVEC:   mtvec   <= csr_wdata;
                CSR_MEPC:    mepc    <= csr_wdata;
                CSR_MCAUSE:  mcause  <= csr_wdata;
                default:     ;
            endcase
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; expected values are hand-computed and follow RF_BYPASS_EN.
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata, rdata1, rdata2;
    logic        a0_zero;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;

    int checks   = 0;
    int failures = 0;

    register_file dut (
        .clk(clk), .rst(rst),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .a0_zero(a0_zero),
        .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drive a GPR write at the negedge, commit on the posedge, then drop wen
    task automatic gpr_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0;
        csr_wen = 1'b0; csr_addr = '0; csr_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Post-reset state
        raddr1 = 5'd10; raddr2 = 5'd31; csr_addr = 12'h300; #1;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_a0_zero", {31'b0, a0_zero}, 32'h1);
        chk("rst_mstatus", csr_rdata, 32'h0000_1800);
        csr_addr = 12'h305; #1;
        chk("rst_mtvec", csr_rdata, 32'h0);

        // Write x5 and read it on both ports; x0 write is dropped
        gpr_wr(5'd5, 32'hDEAD_BEEF);
        raddr1 = 5'd5; raddr2 = 5'd5; #1;
        chk("x5_port1", rdata1, 32'hDEAD_BEEF);
        chk("x5_port2", rdata2, 32'hDEAD_BEEF);
        gpr_wr(5'd0, 32'h0000_1234);
        raddr1 = 5'd0; #1;
        chk("x0_reads_zero", rdata1, 32'h0);
        chk("x5_still", rdata2, 32'hDEAD_BEEF);

        // a0_zero tracks x10
        @(negedge clk);
        wen = 1'b1; waddr = 5'd10; wdata = 32'd7; #1;
`ifdef RF_BYPASS_EN
        chk("a0_before_edge", {31'b0, a0_zero}, 32'h0);
`else
        chk("a0_before_edge", {31'b0, a0_zero}, 32'h1);
`endif
        @(posedge clk); #1; wen = 1'b0; #1;
        chk("a0_after_7", {31'b0, a0_zero}, 32'h0);
        gpr_wr(5'd10, 32'd0); #1;
        chk("a0_after_0", {31'b0, a0_zero}, 32'h1);

        // Read-during-write on x3
        @(negedge clk);
        wen = 1'b1; waddr = 5'd3; wdata = 32'h55; raddr1 = 5'd3; #1;
`ifdef RF_BYPASS_EN
        chk("rdw_same_cycle", rdata1, 32'h55);
`else
        chk("rdw_same_cycle", rdata1, 32'h0);
`endif
        @(posedge clk); #1; wen = 1'b0; #1;
        chk("rdw_after_edge", rdata1, 32'h55);

        // CSR write to mepc: old value during the write cycle
        @(negedge clk);
        csr_wen = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h8000_0010; #1;
`ifdef RF_BYPASS_EN
        chk("mepc_same_cycle", csr_rdata, 32'h8000_0010);
`else
        chk("mepc_same_cycle", csr_rdata, 32'h0);
`endif
        @(posedge clk); #1; csr_wen = 1'b0; #1;
        chk("mepc_after_edge", csr_rdata, 32'h8000_0010);

        // Unmapped CSR write is ignored and disturbs nothing
        @(negedge clk);
        csr_wen = 1'b1; csr_addr = 12'h7C0; csr_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1; csr_wen = 1'b0; #1;
        chk("unmapped_reads_0", csr_rdata, 32'h0);
        csr_addr = 12'h300; #1; chk("mstatus_kept", csr_rdata, 32'h0000_1800);
        csr_addr = 12'h305; #1; chk("mtvec_kept", csr_rdata, 32'h0);
        csr_addr = 12'h341; #1; chk("mepc_kept", csr_rdata, 32'h8000_0010);
        csr_addr = 12'h342; #1; chk("mcause_kept", csr_rdata, 32'h0);

        // GPR and CSR writes in the same cycle both commit
        @(negedge clk);
        wen = 1'b1; waddr = 5'd1; wdata = 32'h0000_0011;
        csr_wen = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0100;
        @(posedge clk); #1; wen = 1'b0; csr_wen = 1'b0;
        raddr1 = 5'd1; #1;
        chk("dual_x1", rdata1, 32'h0000_0011);
        chk("dual_mtvec", csr_rdata, 32'h0000_0100);

        // Pending writes, then asynchronous reset between edges
        @(negedge clk);
        wen = 1'b1; waddr = 5'd1; wdata = 32'h0000_0022;
        csr_wen = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0200;
        #2; rst = 1'b1; #1;
        chk("arst_x1", rdata1, 32'h0);
        chk("arst_mtvec", csr_rdata, 32'h0);
        raddr2 = 5'd5; #1;
        chk("arst_x5", rdata2, 32'h0);
        csr_addr = 12'h341; #1;
        chk("arst_mepc", csr_rdata, 32'h0);
        csr_addr = 12'h305;
        // Writes held across an edge while in reset must not land
        @(posedge clk); #1;
        chk("rst_hold_x1", rdata1, 32'h0);
        chk("rst_hold_mtvec", csr_rdata, 32'h0);
        chk("rst_hold_a0", {31'b0, a0_zero}, 32'h1);
        @(negedge clk);
        wen = 1'b0; csr_wen = 1'b0; rst = 1'b0; #1;
        chk("post_rst_x1", rdata1, 32'h0);
        chk("post_rst_mtvec", csr_rdata, 32'h0);
        csr_addr = 12'h300; #1;
        chk("post_rst_mstatus", csr_rdata, 32'h0000_1800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
